// File: rtl/am_demodulation_pkg.sv
// Shared types and helpers for the AM envelope demodulator.
// The upstream test generator reuses abs_sat8.
package am_pkg;

   localparam int SAMPLE_W = 8;
   localparam int RECT_W   = 7;

   typedef enum logic {
      FILL,
      RUN
   } fill_state_t;

   // |x| clipped to 7 bits; -128 has no positive twin, so it clips to 127.
   function automatic logic [RECT_W-1:0] abs_sat8(
      input logic signed [SAMPLE_W-1:0] x
   );
      logic [SAMPLE_W-1:0] m;
      if (x == 8'sh80) begin
         return 7'd127;
      end
      m = x[SAMPLE_W-1] ? (~x + 8'd1) : x;
      return m[RECT_W-1:0];
   endfunction

endpackage

// File: rtl/am_demodulation_if.sv
// Sample-in / envelope-out bundle of the AM demodulator.
// master drives samples and clear, slave returns the envelope.
interface am_demodulation_if;
   import am_pkg::*;

   logic signed [SAMPLE_W-1:0] AM_mod;
   logic                       clear;
   logic [7:0]                 env;
   logic                       env_valid;
   logic                       sig_present;
   logic                       filling;

   modport master (
      output AM_mod, clear,
      input  env, env_valid, sig_present, filling
   );

   modport slave (
      input  AM_mod, clear,
      output env, env_valid, sig_present, filling
   );

endinterface

// File: rtl/am_demodulation_boxcar_avg.sv
// N-tap boxcar: circular buffer plus running sum.
// Old samples read as zero until the window has been filled once.
module boxcar_avg #(
   parameter int LOG2_N = 4,
   parameter int RECT_W = 7
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic [RECT_W-1:0]        in_data,
   output logic [RECT_W+LOG2_N-1:0] sum,
   output logic                     upd,
   output logic                     run,
   output logic                     filling
);
   import am_pkg::*;

   localparam int N  = 1 << LOG2_N;
   localparam int SW = RECT_W + LOG2_N;

   logic [RECT_W-1:0] mem [N];
   logic [LOG2_N-1:0] wr_ptr;
   logic [LOG2_N-1:0] fill_cnt;
   logic [RECT_W-1:0] old;
   fill_state_t       state;

   assign old = (state == RUN) ? mem[wr_ptr] : '0;
   assign run = (state == RUN);

   // Sample store; never cleared, stale entries are masked during FILL.
   always_ff @(posedge clk) begin
      if (in_valid && !clear) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Running sum, write pointer and FILL/RUN sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum      <= '0;
         wr_ptr   <= '0;
         fill_cnt <= '0;
         state    <= FILL;
         filling  <= 1'b1;
         upd      <= 1'b0;
      end else if (clear) begin
         sum      <= '0;
         wr_ptr   <= '0;
         fill_cnt <= '0;
         state    <= FILL;
         filling  <= 1'b1;
         upd      <= 1'b0;
      end else begin
         upd <= in_valid;
         if (in_valid) begin
            sum    <= sum + SW'(in_data) - SW'(old);
            wr_ptr <= wr_ptr + 1'b1;
            unique case (state)
               FILL: begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == LOG2_N'(N - 1)) begin
                     state   <= RUN;
                     filling <= 1'b0;
                  end
               end
               RUN: begin
                  fill_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/am_demodulation.sv
// Envelope-detector AM demodulator: rectify, boxcar, decimate.
// Pipeline is rect -> sum -> env, with clear flushing all stages.
module am_demodulation #(
   parameter int LOG2_N = 4,
   parameter int DECIM  = 4,
   parameter int THRESH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   am_demodulation_if.slave  bus
);
   import am_pkg::*;

   localparam int SW = RECT_W + LOG2_N;

   logic [RECT_W-1:0] rect;
   logic              rect_v;
   logic [SW-1:0]     sum;
   logic              upd;
   logic              run;
   logic              filling;
   logic [7:0]        env_nxt;
   logic [7:0]        env;
   logic              env_valid;
   logic              sig_present;
   logic [7:0]        dec_cnt;

   // Stage 0: full-wave rectify the incoming sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rect   <= '0;
         rect_v <= 1'b0;
      end else if (bus.clear) begin
         rect   <= '0;
         rect_v <= 1'b0;
      end else begin
         rect   <= abs_sat8(bus.AM_mod);
         rect_v <= 1'b1;
      end
   end

   boxcar_avg #(
      .LOG2_N (LOG2_N),
      .RECT_W (RECT_W)
   ) u_boxcar (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (bus.clear),
      .in_valid (rect_v),
      .in_data  (rect),
      .sum      (sum),
      .upd      (upd),
      .run      (run),
      .filling  (filling)
   );

   assign env_nxt = {1'b0, sum[LOG2_N+RECT_W-1:LOG2_N]};

   // Stage 2: divide by N, decimate strobes, latch the presence flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         env         <= '0;
         env_valid   <= 1'b0;
         sig_present <= 1'b0;
         dec_cnt     <= '0;
      end else if (bus.clear) begin
         env         <= '0;
         env_valid   <= 1'b0;
         sig_present <= 1'b0;
         dec_cnt     <= '0;
      end else begin
         env_valid <= 1'b0;
         if (upd) begin
            env <= env_nxt;
            if (run) begin
               if (dec_cnt == 8'd0) begin
                  env_valid   <= 1'b1;
                  sig_present <= (env_nxt >= 8'(THRESH));
               end
               dec_cnt <= (dec_cnt == 8'(DECIM - 1)) ? 8'd0
                                                     : dec_cnt + 8'd1;
            end
         end
      end
   end

   assign bus.env         = env;
   assign bus.env_valid   = env_valid;
   assign bus.sig_present = sig_present;
   assign bus.filling     = filling;

endmodule

// File: tb/tb_am_demodulation.sv
// Directed bench for am_demodulation: default build plus
// a LOG2_N=2, DECIM=1 build sharing clock and reset.
module tb_am_demodulation;
   import am_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   am_demodulation_if b  ();
   am_demodulation_if b2 ();

   am_demodulation #(
      .LOG2_N (4),
      .DECIM  (4),
      .THRESH (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b.slave)
   );

   am_demodulation #(
      .LOG2_N (2),
      .DECIM  (1),
      .THRESH (8)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d @%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycn(input int n);
      repeat (n) cyc();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_env"}, 32'(b.env), 0);
      chk({tag, "_ev"}, 32'(b.env_valid), 0);
      chk({tag, "_sp"}, 32'(b.sig_present), 0);
      chk({tag, "_fill"}, 32'(b.filling), 1);
   endtask

   task automatic wait_strobe();
      int i;
      i = 0;
      do begin
         cyc();
         i++;
      end while (b.env_valid !== 1'b1 && i < 8);
      chk("strobe_seen", 32'(b.env_valid), 1);
   endtask

   // Entered with rst_n low; ends four cycles after the first strobe.
   task automatic powerup();
      b.AM_mod = 8'sd50;
      cycn(2);
      chk_reset("rst");
      rst_n    = 1'b1;
      b.AM_mod = 8'sd64;
      for (int n = 1; n <= 17; n++) begin
         cyc();
         chk("fill_ev", 32'(b.env_valid), 0);
         if (n == 3) chk("fill_partial", 32'(b.env), 4);
         if (n == 16) chk("filling_16", 32'(b.filling), 1);
      end
      chk("filling_drop", 32'(b.filling), 0);
      cyc();
      chk("first_env", 32'(b.env), 64);
      chk("first_ev", 32'(b.env_valid), 1);
      chk("first_sp", 32'(b.sig_present), 1);
      for (int n = 1; n <= 4; n++) begin
         cyc();
         chk("ev_period", 32'(b.env_valid), 32'(n == 4));
         chk("run_env", 32'(b.env), 64);
      end
   endtask

   initial begin
      logic [31:0] exp_env;
      logic        exp_sp;
      int          strobes;

      b.AM_mod  = 8'sd50;
      b.clear   = 1'b0;
      b2.AM_mod = 8'sd37;
      b2.clear  = 1'b1;
      rst_n     = 1'b0;

      powerup();

      b.AM_mod = 8'sh80;
      cycn(20);
      for (int n = 0; n < 4; n++) begin
         cyc();
         chk("sat_env", 32'(b.env), 127);
      end

      for (int i = 0; i < 24; i++) begin
         b.AM_mod = i[0] ? -8'sd100 : 8'sd100;
         cyc();
      end
      for (int i = 0; i < 8; i++) begin
         b.AM_mod = i[0] ? -8'sd100 : 8'sd100;
         cyc();
         chk("alt_env", 32'(b.env), 100);
      end
      chk("alt_sp", 32'(b.sig_present), 1);

      b.AM_mod = 8'sd0;
      cycn(20);
      chk("zero_env", 32'(b.env), 0);
      wait_strobe();
      chk("zero_sp", 32'(b.sig_present), 0);
      exp_sp   = 1'b0;
      strobes  = 0;
      b.AM_mod = 8'sd80;
      for (int n = 1; n <= 18; n++) begin
         cyc();
         exp_env = (n >= 3) ? 32'(5 * (n - 2)) : 32'd0;
         chk("step_env", 32'(b.env), exp_env);
         if (b.env_valid === 1'b1) begin
            strobes++;
            exp_sp = (exp_env >= 8);
         end
         chk("step_sp", 32'(b.sig_present), 32'(exp_sp));
      end
      chk("step_strobes", 32'(strobes), 4);

      b.AM_mod = 8'sd64;
      cycn(20);
      chk("pre_clr_env", 32'(b.env), 64);
      b.clear = 1'b1;
      cyc();
      b.clear = 1'b0;
      chk_reset("clr");
      for (int n = 1; n <= 17; n++) begin
         cyc();
         chk("clr_ev", 32'(b.env_valid), 0);
      end
      chk("clr_filling", 32'(b.filling), 0);
      cyc();
      chk("clr_env", 32'(b.env), 64);
      chk("clr_strobe", 32'(b.env_valid), 1);
      chk("clr_sp", 32'(b.sig_present), 1);

      cycn(3);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("async");
      powerup();

      b2.clear = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         cyc();
         if (n == 3) chk("sw_partial", 32'(b2.env), 9);
         if (n == 4) chk("sw_fill4", 32'(b2.filling), 1);
         if (n == 5) chk("sw_fill5", 32'(b2.filling), 0);
         if (n <= 5) chk("sw_ev_fill", 32'(b2.env_valid), 0);
         if (n >= 6) begin
            chk("sw_env", 32'(b2.env), 37);
            chk("sw_ev", 32'(b2.env_valid), 1);
            chk("sw_sp", 32'(b2.sig_present), 1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
